// File: rtl/bch_err_gen_pkg.sv
// Shared definitions for the BCH stimulus generator: mode codes, LFSR feedback,
// seed sanitising and BCH geometry helpers.
`timescale 1ns/1ps
package bch_err_gen_pkg;

   localparam logic [1:0] ERRGEN_FIXED    = 2'd0;
   localparam logic [1:0] ERRGEN_RANDOM   = 2'd1;
   localparam logic [1:0] ERRGEN_OVERLOAD = 2'd2;
   localparam logic [1:0] ERRGEN_CLEAN    = 2'd3;

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PICK, S_STREAM} state_t;

   // A zero seed would lock the LFSR, so it is replaced by 1.
   function automatic logic [31:0] fix_seed(input logic [31:0] s);
      return (s == 32'd0) ? 32'd1 : s;
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction

   // Smallest field degree m with 2^m-1 >= data + m*t (shortened BCH code).
   function automatic int bch_m(input int data_bits, input int t);
      int m;
      m = 16;
      for (int i = 16; i >= 3; i--)
         if (((1 << i) - 1) >= data_bits + i * t) m = i;
      return m;
   endfunction

   function automatic int bch_code_bits(input int data_bits, input int t);
      return data_bits + bch_m(data_bits, t) * t;
   endfunction

endpackage

// File: rtl/bch_lfsr32.sv
// 32-bit Galois LFSR next-state logic, unrolled STEPS shifts per call.
`timescale 1ns/1ps
module bch_lfsr32
   import bch_err_gen_pkg::*;
#(
   parameter int STEPS = 1
) (
   input  logic [31:0] i_state,
   output logic [31:0] o_state
);

   logic [31:0] w_s;

   always_comb begin
      w_s = i_state;
      for (int i = 0; i < STEPS; i++) w_s = lfsr_step(w_s);
   end

   assign o_state = w_s;

endmodule

// File: rtl/bch_err_gen.sv
// Per-frame BCH stimulus: pseudo-random message bits plus a codeword error mask
// with a controlled count of distinct flips, streamed BITS per beat.
`timescale 1ns/1ps
module bch_err_gen
   import bch_err_gen_pkg::*;
#(
   parameter int          DATA_BITS = 64,
   parameter int          T         = 4,
   parameter int          BITS      = 8,
   parameter logic [31:0] SEED      = 32'h0,
   localparam int         NERR_W    = $clog2(T + 2)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [NERR_W-1:0] fixed_nerr,
   input  logic              seed_load,
   input  logic [31:0]       seed,
   output logic              ready,
   output logic              valid,
   input  logic              out_ready,
   output logic [BITS-1:0]   data_out,
   output logic              data_en,
   output logic [BITS-1:0]   err_out,
   output logic              first,
   output logic              last,
   output logic [NERR_W-1:0] nerr_out,
   output logic [31:0]       frames
);

   localparam int CODE_BITS = bch_code_bits(DATA_BITS, T);
   localparam int POS_W     = $clog2(CODE_BITS);
   localparam int POS_W1    = POS_W + 1;
   localparam int RND_W     = $clog2(T + 1);
   localparam int RND_W1    = RND_W + 1;
   localparam int NBEATS    = (CODE_BITS + BITS - 1) / BITS;
   localparam int BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   localparam logic [31:0]       RST_SEED  = fix_seed(SEED);
   localparam logic [NERR_W-1:0] NMAX      = NERR_W'(T + 1);
   localparam logic [POS_W:0]    CODE_LIM  = POS_W1'(CODE_BITS);
   localparam logic [RND_W:0]    T_LIM     = RND_W1'(T);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

   state_t              r_state;
   logic [1:0]          r_mode;
   logic [NERR_W-1:0]   r_fixed;
   logic [NERR_W-1:0]   r_nerr;
   logic [NERR_W-1:0]   r_cnt;
   logic [POS_W-1:0]    r_table [T+1];
   logic [31:0]         r_plfsr;
   logic [31:0]         r_dlfsr;
   logic [BEAT_W-1:0]   r_beat;
   logic [31:0]         r_frames;
   logic                r_valid;
   logic                r_first;
   logic                r_last;
   logic                r_den;
   logic [BITS-1:0]     r_data;
   logic [BITS-1:0]     r_err;

   logic [31:0]         w_pnext;
   logic [31:0]         w_dnext;
   logic [POS_W-1:0]    w_cand;
   logic                w_dup;
   logic                w_cand_ok;
   logic [RND_W-1:0]    w_rnd;
   logic                w_rnd_ok;
   logic [BEAT_W-1:0]   w_nb;
   logic [BITS-1:0]     w_dsrc;
   logic [31:0]         w_base;
   logic [BITS-1:0]     w_data;
   logic [BITS-1:0]     w_err;
   logic                w_den;

   bch_lfsr32 #(.STEPS(1))    u_pos_lfsr  (.i_state(r_plfsr), .o_state(w_pnext));
   bch_lfsr32 #(.STEPS(BITS)) u_data_lfsr (.i_state(r_dlfsr), .o_state(w_dnext));

   assign w_cand   = w_pnext[POS_W-1:0];
   assign w_rnd    = w_pnext[RND_W-1:0];
   assign w_rnd_ok = ({1'b0, w_rnd} <= T_LIM);

   // Duplicate check only looks at entries already filled this frame.
   always_comb begin
      w_dup = 1'b0;
      for (int k = 0; k <= T; k++)
         if ((NERR_W'(k) < r_cnt) && (r_table[k] == w_cand)) w_dup = 1'b1;
   end

   assign w_cand_ok = ({1'b0, w_cand} < CODE_LIM) && !w_dup;

   // Beat to present next: beat 0 on entry to STREAM, else the following beat.
   assign w_nb   = (r_state == S_STREAM) ? r_beat + 1'b1 : '0;
   assign w_dsrc = ((r_state == S_STREAM) && r_den) ? w_dnext[BITS-1:0] : r_dlfsr[BITS-1:0];

   always_comb begin
      w_base = 32'(w_nb) * 32'(BITS);
      w_den  = (w_base < 32'(DATA_BITS));
      w_data = '0;
      w_err  = '0;
      for (int j = 0; j < BITS; j++) begin
         if ((w_base + 32'(j)) < 32'(DATA_BITS)) w_data[j] = w_dsrc[j];
         for (int k = 0; k <= T; k++)
            if ((NERR_W'(k) < r_nerr) && (32'(r_table[k]) == w_base + 32'(j))
                && ((w_base + 32'(j)) < 32'(CODE_BITS)))
               w_err[j] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_mode   <= ERRGEN_FIXED;
         r_fixed  <= '0;
         r_nerr   <= '0;
         r_cnt    <= '0;
         for (int k = 0; k <= T; k++) r_table[k] <= '0;
         r_plfsr  <= RST_SEED;
         r_dlfsr  <= RST_SEED;
         r_beat   <= '0;
         r_frames <= '0;
         r_valid  <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
         r_den    <= 1'b0;
         r_data   <= '0;
         r_err    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode  <= mode;
                  r_fixed <= fixed_nerr;
                  r_cnt   <= '0;
                  r_state <= S_COUNT;
               end else if (seed_load) begin
                  r_plfsr <= fix_seed(seed);
                  r_dlfsr <= fix_seed(seed);
               end
            end
            S_COUNT: begin
               case (r_mode)
                  ERRGEN_FIXED: begin
                     r_nerr  <= (r_fixed > NMAX) ? NMAX : r_fixed;
                     r_state <= S_PICK;
                  end
                  ERRGEN_RANDOM: begin
                     r_plfsr <= w_pnext;
                     if (w_rnd_ok) begin
                        r_nerr  <= NERR_W'(w_rnd);
                        r_state <= S_PICK;
                     end
                  end
                  ERRGEN_OVERLOAD: begin
                     r_nerr  <= NMAX;
                     r_state <= S_PICK;
                  end
                  default: begin
                     r_nerr  <= '0;
                     r_state <= S_PICK;
                  end
               endcase
            end
            S_PICK: begin
               if (r_cnt == r_nerr) begin
                  r_beat  <= '0;
                  r_valid <= 1'b1;
                  r_first <= 1'b1;
                  r_last  <= (w_nb == LAST_BEAT);
                  r_den   <= w_den;
                  r_data  <= w_data;
                  r_err   <= w_err;
                  r_state <= S_STREAM;
               end else begin
                  r_plfsr <= w_pnext;
                  if (w_cand_ok) begin
                     r_table[r_cnt] <= w_cand;
                     r_cnt          <= r_cnt + 1'b1;
                  end
               end
            end
            S_STREAM: begin
               if (r_valid && out_ready) begin
                  if (r_den) r_dlfsr <= w_dnext;
                  if (r_last) begin
                     r_valid  <= 1'b0;
                     r_first  <= 1'b0;
                     r_last   <= 1'b0;
                     r_den    <= 1'b0;
                     r_data   <= '0;
                     r_err    <= '0;
                     r_frames <= r_frames + 32'd1;
                     r_state  <= S_IDLE;
                  end else begin
                     r_beat  <= w_nb;
                     r_first <= 1'b0;
                     r_last  <= (w_nb == LAST_BEAT);
                     r_den   <= w_den;
                     r_data  <= w_data;
                     r_err   <= w_err;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready    = (r_state == S_IDLE);
   assign valid    = r_valid;
   assign first    = r_first;
   assign last     = r_last;
   assign data_en  = r_den;
   assign data_out = r_data;
   assign err_out  = r_err;
   assign nerr_out = r_nerr;
   assign frames   = r_frames;

endmodule

// File: tb/tb_bch_err_gen.sv
// Scoreboarded bench for bch_err_gen: a reference frame model queues expected
// beats at start; beats are popped and compared as the DUT hands them over.
`timescale 1ns/1ps
module tb_bch_err_gen;

   localparam int DB = 64, TT = 4, CB = 92, BW = 8, NB = 12, NW = 3;
   localparam int LIM = 4000;

   typedef struct packed {
      logic [BW-1:0] data;
      logic [BW-1:0] err;
      logic          first;
      logic          last;
      logic          den;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset, start, seed_load, out_ready;
   logic [1:0]    mode;
   logic [NW-1:0] fixed_nerr, nerr_out;
   logic [31:0]   seed, frames;
   logic          ready, valid, data_en, first, last;
   logic [BW-1:0] data_out, err_out;

   bch_err_gen #(.DATA_BITS(DB), .T(TT), .BITS(BW), .SEED(32'h0)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .fixed_nerr(fixed_nerr),
      .seed_load(seed_load), .seed(seed), .ready(ready), .valid(valid),
      .out_ready(out_ready), .data_out(data_out), .data_en(data_en), .err_out(err_out),
      .first(first), .last(last), .nerr_out(nerr_out), .frames(frames));

   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   beat_t       sb[$];
   logic [31:0] m_p, m_d;
   int          exp_frames;
   bit          stall_en, held_v, prev_last;
   beat_t       held;
   int          beats_acc, pop_acc;
   int          hist [TT+2];

   function automatic logic [31:0] step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference frame: count resolution, rejection-sampled distinct positions, beats.
   task automatic model_frame(input int md, input int fx, output int ne);
      int    tab[$];
      int    c, base, guard;
      bit    dup;
      beat_t b;
      case (md)
         0: ne = (fx > TT + 1) ? TT + 1 : fx;
         1: begin
            ne = -1; guard = 0;
            while (ne < 0 && guard < 1000) begin
               m_p = step(m_p); guard++;
               if (int'(m_p[2:0]) <= TT) ne = int'(m_p[2:0]);
            end
         end
         2: ne = TT + 1;
         default: ne = 0;
      endcase
      while (tab.size() < ne) begin
         m_p = step(m_p);
         c = int'(m_p[6:0]);
         dup = 1'b0;
         foreach (tab[k]) if (tab[k] == c) dup = 1'b1;
         if (c < CB && !dup) tab.push_back(c);
      end
      for (int bi = 0; bi < NB; bi++) begin
         base = bi * BW;
         b = '0;
         b.first = (bi == 0);
         b.last  = (bi == NB - 1);
         b.den   = (base < DB);
         for (int j = 0; j < BW; j++) begin
            if (base + j < DB) b.data[j] = m_d[j];
            foreach (tab[k]) if (tab[k] == base + j) b.err[j] = 1'b1;
         end
         sb.push_back(b);
         if (b.den) for (int s = 0; s < BW; s++) m_d = step(m_d);
      end
   endtask

   // Runs at each falling edge: checks held beats, chooses out_ready, scores handshakes.
   task automatic mon_step;
      beat_t obs, e;
      if (reset) begin
         out_ready = 1'b1; held_v = 1'b0; prev_last = 1'b0;
         return;
      end
      obs = '{data: data_out, err: err_out, first: first, last: last, den: data_en};
      if (prev_last) chk("ready_after_last", {62'd0, valid, ready}, 64'b01);
      prev_last = 1'b0;
      if (held_v) chk("stall_hold", {44'd0, valid, obs}, {44'd0, 1'b1, held});
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      held_v = valid && !out_ready;
      held = obs;
      if (valid && out_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_beat observed=%0h expected=none", obs);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("beat", {45'd0, obs}, {45'd0, e});
         end
         beats_acc++;
         pop_acc += $countones(err_out);
         prev_last = last;
      end
   endtask

   task automatic tick;
      @(negedge clk);
      mon_step();
      #2;
   endtask

   task automatic do_reset;
      reset = 1'b1; start = 1'b0; seed_load = 1'b0;
      sb.delete();
      tick(); tick();
      reset = 1'b0;
      m_p = 32'd1; m_d = 32'd1; exp_frames = 0;
   endtask

   task automatic load_seed(input logic [31:0] s);
      seed_load = 1'b1; seed = s;
      tick();
      seed_load = 1'b0;
      m_p = (s == 0) ? 32'd1 : s;
      m_d = m_p;
   endtask

   // One frame; with poke set, start and seed_load are pulsed mid-stream.
   task automatic do_frame(input int md, input int fx, input bit poke);
      int ne, to;
      bit poked;
      to = 0;
      while (!ready && to < LIM) begin tick(); to++; end
      model_frame(md, fx, ne);
      beats_acc = 0; pop_acc = 0; poked = 1'b0;
      mode = 2'(md); fixed_nerr = NW'(fx); start = 1'b1;
      tick();
      start = 1'b0;
      exp_frames++;
      to = 0;
      while ((sb.size() != 0 || !ready) && to < LIM) begin
         if (poke && !poked && beats_acc == 2) begin
            start = 1'b1; seed_load = 1'b1; seed = 32'h1234_5678; mode = 2'd2;
            poked = 1'b1;
         end
         tick(); to++;
         start = 1'b0; seed_load = 1'b0;
      end
      chk("frame_done", {63'd0, to < LIM}, 64'd1);
      chk("nerr_out", 64'(nerr_out), 64'(ne));
      chk("popcount", 64'(pop_acc), 64'(ne));
      chk("beat_count", 64'(beats_acc), 64'(NB));
      chk("frames", 64'(frames), 64'(exp_frames));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0;
      mode = '0; fixed_nerr = '0; out_ready = 1'b1; stall_en = 1'b0;
      held_v = 1'b0; prev_last = 1'b0;
      foreach (hist[k]) hist[k] = 0;
      do_reset();
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_first_last", {62'd0, first, last}, 64'd0);
      chk("rst_data", 64'(data_out), 64'd0);
      chk("rst_err", 64'(err_out), 64'd0);
      chk("rst_nerr", 64'(nerr_out), 64'd0);
      chk("rst_frames", 64'(frames), 64'd0);

      do_frame(0, 3, 1'b0);
      do_frame(2, 0, 1'b0);
      do_frame(3, 2, 1'b0);
      do_frame(0, 7, 1'b0);
      do_frame(0, 0, 1'b0);
      do_frame(0, 1, 1'b1);

      for (int f = 0; f < 200; f++) begin
         do_frame(1, 0, 1'b0);
         if (int'(nerr_out) <= TT + 1) hist[nerr_out]++;
      end
      for (int k = 0; k <= TT; k++) chk($sformatf("rand_hist_%0d", k), {63'd0, hist[k] > 0}, 64'd1);

      load_seed(32'hDEAD_BEEF);
      do_frame(0, 2, 1'b0);
      do_frame(1, 0, 1'b0);
      do_reset();
      load_seed(32'hDEAD_BEEF);
      stall_en = 1'b1;
      do_frame(0, 2, 1'b0);
      do_frame(1, 0, 1'b0);
      stall_en = 1'b0;

      load_seed(32'h0);
      do_frame(0, 4, 1'b0);

      // Abort a frame with reset once beats 0..2 have been presented.
      do_reset();
      begin
         int ne, to;
         model_frame(0, 3, ne);
         beats_acc = 0;
         mode = 2'd0; fixed_nerr = 3'd3; start = 1'b1;
         tick();
         start = 1'b0;
         to = 0;
         while (beats_acc < 3 && to < LIM) begin tick(); to++; end
         chk("abort_reached", {63'd0, to < LIM}, 64'd1);
         reset = 1'b1;
         sb.delete();
         tick();
         chk("abort_valid", 64'(valid), 64'd0);
         chk("abort_ready", 64'(ready), 64'd1);
         chk("abort_frames", 64'(frames), 64'd0);
         reset = 1'b0;
         m_p = 32'd1; m_d = 32'd1; exp_frames = 0;
      end
      do_frame(2, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
